// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, widths and the default bit period.
// Used by uart_tx, uart_bit_timer and the matching receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 32;
  localparam logic [CNT_W-1:0] DEFAULT_CLKS_PER_BIT = 32'd2000000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clocks and flags the last clock of each serial bit.
// Clear wins over enable; the count never exceeds CLKS_PER_BIT-1 when cleared on terminal.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter logic [CNT_W-1:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign tc = (count_reg == CLKS_PER_BIT - 32'd1);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake, sent LSB first as 8N1 (or 8E1 when
// the UART_TX_PARITY_EN macro is defined), CLKS_PER_BIT clocks per bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [CNT_W-1:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_DV,
  input  logic [7:0] Tx_Byte,
  output logic       Tx_Ready,
  output logic       Tx_Active,
  output logic       Tx_Serial,
  output logic       Tx_Done
);

  uart_state_e    state_reg;
  logic [7:0]     shift_reg;
  logic [2:0]     index_reg;
  logic [2:0]     index_next;
  logic           serial_reg;
  logic           ready_reg;
  logic           active_reg;
  logic           done_reg;
  logic           bit_tc;
  logic           timer_clear;

  // Timer is held at zero while idle so the start bit gets a full period.
  assign timer_clear = (state_reg == ST_IDLE) || bit_tc;
  assign index_next  = index_reg + 3'd1;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clk   (Clk),
    .Rst   (Rst),
    .clear (timer_clear),
    .enable(1'b1),
    .tc    (bit_tc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      index_reg  <= '0;
      serial_reg <= 1'b1;
      ready_reg  <= 1'b1;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          serial_reg <= 1'b1;
          ready_reg  <= 1'b1;
          active_reg <= 1'b0;
          if (Tx_DV) begin
            shift_reg  <= Tx_Byte;
            serial_reg <= 1'b0;
            ready_reg  <= 1'b0;
            active_reg <= 1'b1;
            state_reg  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tc) begin
            index_reg  <= '0;
            serial_reg <= shift_reg[0];
            state_reg  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tc) begin
            if (index_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              serial_reg <= even_parity(shift_reg);
              state_reg  <= ST_PARITY;
`else
              serial_reg <= 1'b1;
              state_reg  <= ST_STOP;
`endif
            end else begin
              index_reg  <= index_next;
              serial_reg <= shift_reg[index_next];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tc) begin
            serial_reg <= 1'b1;
            state_reg  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tc) begin
            done_reg   <= 1'b1;
            ready_reg  <= 1'b1;
            active_reg <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encodings recover to idle with reset-valued outputs.
          state_reg  <= ST_IDLE;
          index_reg  <= '0;
          serial_reg <= 1'b1;
          ready_reg  <= 1'b1;
          active_reg <= 1'b0;
          done_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign Tx_Serial = serial_reg;
  assign Tx_Ready  = ready_reg;
  assign Tx_Active = active_reg;
  assign Tx_Done   = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.
// Expected line levels come from the frame layout: start, data LSB first, [parity], stop.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       Clk;
  logic       Rst;
  logic       Tx_DV;
  logic [7:0] Tx_Byte;
  logic       Tx_Ready;
  logic       Tx_Active;
  logic       Tx_Serial;
  logic       Tx_Done;

  int vectors;
  int miscompares;

  uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Tx_DV    (Tx_DV),
    .Tx_Byte  (Tx_Byte),
    .Tx_Ready (Tx_Ready),
    .Tx_Active(Tx_Active),
    .Tx_Serial(Tx_Serial),
    .Tx_Done  (Tx_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    logic       par;   // even-parity bit worked out by hand
  } vec_t;

  vec_t tbl [7];

  // Outputs are compared as {Tx_Serial, Tx_Ready, Tx_Active, Tx_Done}.
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got serial/ready/active/done=%b required %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {Tx_Serial, Tx_Ready, Tx_Active, Tx_Done};
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // Called at a negedge while idle: requests the byte; returns just after the accepting edge.
  task automatic accept(input logic [7:0] b);
    chk("ready_before_accept", outs(), 4'b1100);
    Tx_DV   = 1'b1;
    Tx_Byte = b;
    @(negedge Clk);
  endtask

  // Follows a frame already accepted. ghost_k: sample index at which a 0x55 request is pulsed.
  task automatic run_frame(input logic [7:0] b, input logic p, input int ghost_k,
                           input bit hold, input logic [7:0] nxt);
    logic [10:0] fr;
    fr = frame_of(b, p);
    for (int k = 0; k < FB * C; k++) begin
      chk($sformatf("frame_%02h_bit%0d", b, k / C), outs(), {fr[k / C], 3'b010});
      if (hold) begin
        Tx_DV   = 1'b1;
        Tx_Byte = b;
      end else if (k == ghost_k) begin
        Tx_DV   = 1'b1;
        Tx_Byte = 8'h55;
      end else begin
        Tx_DV   = 1'b0;
        Tx_Byte = 8'($urandom);
      end
      @(negedge Clk);
    end
    chk($sformatf("done_%02h", b), outs(), 4'b1101);
    if (hold) begin
      Tx_DV   = 1'b1;
      Tx_Byte = nxt;
      @(negedge Clk);
    end else begin
      Tx_DV = 1'b0;
      @(negedge Clk);
      chk($sformatf("idle_after_%02h", b), outs(), 4'b1100);
    end
  endtask

  initial begin
    logic [7:0] rb;
    vectors     = 0;
    miscompares = 0;
    Rst         = 1'b1;
    Tx_DV       = 1'b1;
    Tx_Byte     = 8'hAA;

    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b0};
    tbl[3] = '{8'h3C, 1'b0};
    tbl[4] = '{8'h81, 1'b0};
    tbl[5] = '{8'h07, 1'b1};
    tbl[6] = '{8'h6E, 1'b1};

    repeat (3) @(negedge Clk);
    chk("reset_state", outs(), 4'b1100);
    Rst   = 1'b0;
    Tx_DV = 1'b0;
    @(negedge Clk);
    chk("idle_after_reset", outs(), 4'b1100);

    for (int i = 0; i < 7; i++) begin
      accept(tbl[i].data);
      run_frame(tbl[i].data, tbl[i].par, -1, 1'b0, 8'h00);
    end

    // Request pulsed mid-frame must be ignored.
    accept(8'h0F);
    run_frame(8'h0F, 1'b0, 2 * C + 1, 1'b0, 8'h00);
    for (int k = 0; k < 2 * C; k++) begin
      chk("no_second_frame", outs(), 4'b1100);
      @(negedge Clk);
    end

    // Tx_DV held high: second frame starts one edge after Ready returns.
    accept(8'h12);
    run_frame(8'h12, 1'b0, -1, 1'b1, 8'h34);
    run_frame(8'h34, 1'b1, -1, 1'b0, 8'h00);

    // Reset during data bit 3, asserted together with a request.
    accept(8'hE7);
    for (int k = 0; k < 4 * C + 1; k++) @(negedge Clk);
    chk("mid_frame_before_rst", outs(), {1'b0, 3'b010});
    Rst     = 1'b1;
    Tx_DV   = 1'b1;
    Tx_Byte = 8'h99;
    @(negedge Clk);
    chk("rst_mid_frame", outs(), 4'b1100);
    Rst   = 1'b0;
    Tx_DV = 1'b0;
    for (int k = 0; k < 6 * C; k++) begin
      @(negedge Clk);
      chk("no_done_after_rst", outs(), 4'b1100);
    end
    accept(8'hC3);
    run_frame(8'hC3, 1'b0, -1, 1'b0, 8'h00);

    // Random bytes against the frame model.
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom);
      accept(rb);
      run_frame(rb, ^rb, -1, 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one byte per handshake and shifts it out as an 8N1 frame on a single line, LSB first, at CLKS_PER_BIT clocks per bit. It is the transmit counterpart of `uart_rx` and must interoperate with it when both use the same CLKS_PER_BIT. It sits between the on-chip byte producer and the board TX pin.

## Interface
- CLKS_PER_BIT, default 2000000: clocks per serial bit (50 baud at 100 MHz). Legal range is 2 .. 2^32-1.
- Clk  in  1  system clock; all logic is on its rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Tx_DV  in  1  byte-valid request; sampled only while Tx_Ready=1.
- Tx_Byte  in  8  byte to send; captured on the accepting edge.
- Tx_Ready  out  1  idle and able to accept. Reset value 1.
- Tx_Active  out  1  frame in progress. Reset value 0.
- Tx_Serial  out  1  serial line, registered, idle high. Reset value 1.
- Tx_Done  out  1  one-cycle pulse at end of stop bit. Reset value 0.

## Operation
- Internal state:
  - 32-bit bit-timer count.
  - 3-bit bit index.
  - 8-bit shift/holding register.
- IDLE:
  - Tx_Serial=1, Tx_Ready=1, Tx_Active=0.
  - On an edge with Tx_DV=1: latch Tx_Byte, drive Tx_Serial<=0, Tx_Ready<=0, Tx_Active<=1, count<=0, go to START.
- START:
  - Hold the line at 0 and count.
  - When count==CLKS_PER_BIT-1: count<=0, index<=0, Tx_Serial<=byte[0], go to DATA.
- DATA:
  - Hold byte[index] on the line.
  - At terminal count with index<7: index+1, drive the next bit.
  - At terminal count with index==7: drive 1 and go to STOP. With parity enabled, drive the parity bit and go to PARITY instead.
- PARITY (macro only): hold the parity bit; at terminal count drive 1 and go to STOP.
- STOP:
  - Hold the line at 1.
  - At terminal count: go to IDLE, Tx_Done<=1 for exactly one cycle, Tx_Ready<=1, Tx_Active<=0.
- Tx_DV while Tx_Ready=0 is ignored. No queuing, no error flag.
- Tx_Byte changes after acceptance do not affect the frame in flight.
- Unused state encodings return to IDLE with outputs at their reset values.

## Timing
- Latency: the line goes low on the edge after Tx_DV is sampled high in IDLE.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- Frame length: 10·CLKS_PER_BIT cycles from the accepting edge to the edge raising Tx_Done (11·CLKS_PER_BIT with parity).
- Back-to-back: Tx_Done and Tx_Ready rise on the same edge. If Tx_DV=1 in that first Ready cycle, the next start bit begins one edge later, so the line is high for CLKS_PER_BIT+1 cycles between frames.
- Reset mid-frame: on the next edge the line returns to 1 and all outputs take reset values. The truncated frame is abandoned and Tx_Done does not pulse.
- Rst has priority over Tx_DV on the same edge.
- Timer compare uses full 32-bit unsigned width; the counter never wraps.

## Configuration
- UART_TX_PARITY_EN defined:
  - One even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and stop.
  - Adds the PARITY state; frame becomes 11 bits.
- Not defined:
  - Plain 8N1 and no PARITY state.
  - This is the default, because `uart_rx` has no parity support.

## Structure
- Shared package `uart_pkg`:
  - state encodings IDLE/START/DATA/PARITY/STOP (3-bit)
  - DATA_BITS=8
  - default CLKS_PER_BIT
  - counter width 32
  - `uart_rx` switches to the same package.
- One sub-module, `uart_bit_timer`:
  - 32-bit counter with clear and enable inputs.
  - Terminal-count output at CLKS_PER_BIT-1.
  - Reusable by `uart_rx`.

## Test plan
- CLKS_PER_BIT=4, send 0xA5:
  - Tx_Serial per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
  - Tx_Done pulses 40 cycles after acceptance; Tx_Ready is low throughout the frame.
- Loopback into `uart_rx` at CLKS_PER_BIT=16: send 0x00, 0xFF, 0x3C, 0x81 -> Rx_Byte matches each, with one Data_Valid per byte.
- Tx_DV pulsed with 0x55 mid-frame while sending 0x0F -> only 0x0F is transmitted and Tx_Done pulses once.
- Tx_DV held high with 0x12 then 0x34 -> both frames sent back-to-back with a line-high gap of CLKS_PER_BIT+1 cycles.
- Rst asserted during DATA bit 3 -> next cycle Tx_Serial=1, Tx_Ready=1, Tx_Active=0, no Tx_Done; a new 0xC3 frame after reset is sent intact.
- With UART_TX_PARITY_EN, CLKS_PER_BIT=4, send 0x07 -> parity bit 1 after bit 7, Tx_Done at 44 cycles.
